// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - refill sequencer sharing one main memory between I-cache and D-cache misses
// D misses win arbitration; a granted block is read as consecutive words and steered to its owner.
module cache_fill_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_miss,
  input  logic [ADDR_W-1:0]                  i_miss_addr,
  input  logic                               d_miss,
  input  logic [ADDR_W-1:0]                  d_miss_addr,
  output logic                               mem_en,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic [15:0]                        mem_data,
  input  logic                               mem_data_valid,
  output logic [15:0]                        fill_data,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic                               fill_i_we,
  output logic                               fill_d_we,
  output logic                               i_fill_done,
  output logic                               d_fill_done,
  output logic                               busy
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        r_state;
  logic              r_owner_d;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_recv_cnt;

  logic              w_in_fill;
  logic              w_issue;
  logic              w_recv;
  logic              w_recv_last;
  logic [ADDR_W-1:0] w_issue_off;

  assign w_in_fill   = (r_state == ST_FILL);
  assign w_issue     = w_in_fill && (r_issue_cnt < CNT_FULL);
  // Returns arriving outside FILL or beyond the block are dropped here.
  assign w_recv      = w_in_fill && mem_data_valid && (r_recv_cnt < CNT_FULL);
  assign w_recv_last = w_recv && (r_recv_cnt == CNT_LAST);
  assign w_issue_off = ADDR_W'(r_issue_cnt) << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner_d   <= 1'b0;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (d_miss) begin
            r_state     <= ST_FILL;
            r_owner_d   <= 1'b1;
            r_base      <= d_miss_addr & BLK_MASK;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
          end else if (i_miss) begin
            r_state     <= ST_FILL;
            r_owner_d   <= 1'b0;
            r_base      <= i_miss_addr & BLK_MASK;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
          end
        end
        ST_FILL: begin
          if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
          if (w_recv)  r_recv_cnt  <= r_recv_cnt + 1'b1;
          if (w_recv_last) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_en      = w_issue;
  assign mem_addr    = w_issue ? (r_base + w_issue_off) : '0;
  assign fill_data   = mem_data;
  assign fill_word   = r_recv_cnt[IDX_W-1:0];
  assign fill_i_we   = w_recv && !r_owner_d;
  assign fill_d_we   = w_recv && r_owner_d;
  assign i_fill_done = (r_state == ST_DONE) && !r_owner_d;
  assign d_fill_done = (r_state == ST_DONE) && r_owner_d;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb/tb_cache_fill_arbiter.sv - self-checking bench for cache_fill_arbiter
// A fixed-latency memory model and a schedule-based reference predict every issue, write and done pulse.
module tb_cache_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss, d_miss;
  logic [15:0] i_miss_addr, d_miss_addr;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_data_valid;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        fill_i_we, fill_d_we, i_fill_done, d_fill_done, busy;

  cache_fill_arbiter #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .fill_data(fill_data), .fill_word(fill_word),
    .fill_i_we(fill_i_we), .fill_d_we(fill_d_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [15:0] addr; } iss_t;
  typedef struct { int cyc; logic is_d; logic [2:0] word; logic [15:0] data; } wr_t;
  typedef struct { int cyc; logic is_d; } dn_t;
  typedef struct {
    int lat; logic i_on; logic [15:0] i_addr; logic d_on; logic [15:0] d_addr;
    int d_delay; logic exp_first_d; int exp_done1; int exp_done2;
  } vec_t;

  iss_t exp_iss[$];
  wr_t  exp_wr[$];
  dn_t  exp_dn[$];
  iss_t rsp_q[$];
  int   obs_dn_cyc[$];
  logic obs_dn_d[$];

  int tests = 0, fails = 0;
  int cyc = 0, lat = 4;
  int m_free = 0, m_busy_from = 0;
  logic i_granted = 0, d_granted = 0;
  logic drv_i = 0, drv_d = 0, drv_stray = 0;
  logic [15:0] drv_i_addr = 0, drv_d_addr = 0;
  int wr_seen = 0;
  logic [2:0] last_wr_word;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference: a grant seen in IDLE at cycle T fixes the whole fill schedule.
  task automatic grant(input logic is_d, input logic [15:0] addr, input int t);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      exp_iss.push_back('{t + 1 + k, base + 16'(2 * k)});
      exp_wr.push_back('{t + 1 + lat + k, is_d, 3'(k), pat(base + 16'(2 * k))});
    end
    exp_dn.push_back('{t + 9 + lat, is_d});
    m_busy_from = t + 1;
    m_free      = t + 10 + lat;
    if (is_d) d_granted = 1; else i_granted = 1;
  endtask

  task automatic check();
    logic e_en, e_w, e_d;
    logic [1:0] e_we, e_dn;
    e_en = (exp_iss.size() > 0) && (exp_iss[0].cyc == cyc);
    chk("mem_en", mem_en, e_en);
    if (e_en) begin
      chk("mem_addr", mem_addr, exp_iss[0].addr);
      void'(exp_iss.pop_front());
    end
    e_w  = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
    e_we = e_w ? (exp_wr[0].is_d ? 2'b10 : 2'b01) : 2'b00;
    chk("fill_we", {fill_d_we, fill_i_we}, e_we);
    if (e_w) begin
      chk("fill_word", fill_word, exp_wr[0].word);
      chk("fill_data", fill_data, exp_wr[0].data);
      void'(exp_wr.pop_front());
    end
    if (fill_i_we || fill_d_we) begin
      wr_seen++;
      last_wr_word = fill_word;
    end
    e_d  = (exp_dn.size() > 0) && (exp_dn[0].cyc == cyc);
    e_dn = e_d ? (exp_dn[0].is_d ? 2'b10 : 2'b01) : 2'b00;
    chk("fill_done", {d_fill_done, i_fill_done}, e_dn);
    if (e_d) begin
      if (exp_dn[0].is_d) begin drv_d = 0; d_granted = 0; end
      else begin drv_i = 0; i_granted = 0; end
      void'(exp_dn.pop_front());
    end
    if (i_fill_done || d_fill_done) begin
      obs_dn_cyc.push_back(cyc);
      obs_dn_d.push_back(d_fill_done);
    end
    chk("busy", busy, (cyc >= m_busy_from) && (cyc < m_free));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    i_miss = drv_i; i_miss_addr = drv_i_addr;
    d_miss = drv_d; d_miss_addr = drv_d_addr;
    mem_data_valid = 0;
    mem_data = 16'($urandom);
    if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
      mem_data_valid = 1;
      mem_data = pat(rsp_q[0].addr);
      void'(rsp_q.pop_front());
    end else if (drv_stray) begin
      mem_data_valid = 1;
    end
    drv_stray = 0;
    #1;
    if (cyc >= m_free && (d_miss || i_miss))
      grant(d_miss, d_miss ? d_miss_addr : i_miss_addr, cyc);
    check();
    if (mem_en) rsp_q.push_back('{cyc + lat, mem_addr});
  endtask

  task automatic drain();
    drv_i = 0; drv_d = 0;
    for (int s = 0; s < 200 && (cyc < m_free || exp_dn.size() > 0); s++) step();
    step();
  endtask

  vec_t vecs[6];

  initial begin
    int t0, w0, x, first_iss, busy_low;
    logic [15:0] first_addr;
    vecs[0] = '{4, 1'b1, 16'h1236, 1'b0, 16'h0000, 0, 1'b0, 13, -1};
    vecs[1] = '{4, 1'b1, 16'h0040, 1'b1, 16'h8008, 0, 1'b1, 13, 27};
    vecs[2] = '{4, 1'b1, 16'h2000, 1'b1, 16'h3008, 3, 1'b0, 13, 27};
    vecs[3] = '{1, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 0, 1'b0, 10, -1};
    vecs[4] = '{1, 1'b1, 16'h0100, 1'b1, 16'h0202, 0, 1'b1, 10, 21};
    vecs[5] = '{7, 1'b0, 16'h0000, 1'b1, 16'h7777, 0, 1'b1, 16, -1};

    rst_n = 0; i_miss = 0; d_miss = 0; i_miss_addr = 0; d_miss_addr = 0;
    mem_data = 0; mem_data_valid = 0;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      mem_data = 16'($urandom); mem_data_valid = 1; i_miss = 1; d_miss = 1;
      #1;
      chk("rst_outs", {mem_en, mem_addr, fill_word, fill_i_we, fill_d_we, i_fill_done, d_fill_done, busy}, 0);
      chk("rst_fill_data", fill_data, mem_data);
    end
    i_miss = 0; d_miss = 0; mem_data_valid = 0;
    #2 rst_n = 1;

    foreach (vecs[v]) begin
      lat = vecs[v].lat;
      obs_dn_cyc.delete(); obs_dn_d.delete();
      t0 = cyc + 1;
      drv_i = vecs[v].i_on; drv_i_addr = vecs[v].i_addr;
      drv_d_addr = vecs[v].d_addr;
      for (int s = 0; s < 60; s++) begin
        if (vecs[v].d_on && s == vecs[v].d_delay) drv_d = 1;
        step();
      end
      drain();
      chk($sformatf("vec%0d_ndone", v), obs_dn_cyc.size(), (vecs[v].exp_done2 < 0) ? 1 : 2);
      if (obs_dn_cyc.size() > 0) begin
        chk($sformatf("vec%0d_done1", v), obs_dn_cyc[0] - t0, vecs[v].exp_done1);
        chk($sformatf("vec%0d_first_d", v), obs_dn_d[0], vecs[v].exp_first_d);
      end
      if (obs_dn_cyc.size() > 1)
        chk($sformatf("vec%0d_done2", v), obs_dn_cyc[1] - t0, vecs[v].exp_done2);
    end

    // Reset mid-fill after three words, then re-request the same block.
    lat = 4; w0 = wr_seen;
    drv_i = 1; drv_i_addr = 16'h4444;
    for (int s = 0; s < 40 && wr_seen - w0 < 3; s++) step();
    chk("rst_mid_writes", wr_seen - w0, 3);
    rst_n = 0; #1;
    chk("rst_mid_outs", {mem_en, mem_addr, fill_word, fill_i_we, fill_d_we, i_fill_done, d_fill_done, busy}, 0);
    chk("rst_mid_fill_data", fill_data, mem_data);
    exp_iss.delete(); exp_wr.delete(); exp_dn.delete(); rsp_q.delete();
    m_free = 0; m_busy_from = 0; i_granted = 0; d_granted = 0;
    i_miss = 0; mem_data_valid = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    obs_dn_cyc.delete();
    w0 = wr_seen; first_addr = 16'hDEAD;
    for (int s = 0; s < 40 && wr_seen == w0; s++) begin
      step();
      if (mem_en && first_addr == 16'hDEAD) first_addr = mem_addr;
    end
    chk("restart_first_addr", first_addr, 16'h4440);
    chk("restart_word0", last_wr_word, 3'd0);
    drain();
    chk("restart_done_count", obs_dn_cyc.size(), 1);

    // Stray valids in IDLE and in DONE.
    w0 = wr_seen; obs_dn_cyc.delete();
    drv_stray = 1; step();
    chk("stray_idle_busy", busy, 0);
    drv_i = 1; drv_i_addr = 16'h0A00;
    for (int s = 0; s < 40; s++) begin
      if (cyc + 1 == m_free - 1) drv_stray = 1;
      step();
    end
    drain();
    chk("stray_writes", wr_seen - w0, 8);
    chk("stray_done_count", obs_dn_cyc.size(), 1);

    // Back-to-back I misses to different blocks.
    lat = 3; obs_dn_cyc.delete();
    drv_i = 1; drv_i_addr = 16'h1000;
    for (int s = 0; s < 40 && obs_dn_cyc.size() == 0; s++) step();
    chk("b2b_first_done", obs_dn_cyc.size(), 1);
    x = cyc; first_iss = -1; busy_low = 0;
    drv_i = 1; drv_i_addr = 16'h2000;
    for (int s = 0; s < 20 && first_iss < 0; s++) begin
      step();
      if (!busy) busy_low++;
      if (mem_en) first_iss = cyc;
    end
    chk("b2b_issue_gap", first_iss - x, 2);
    chk("b2b_busy_low", busy_low, 1);
    chk("b2b_addr", mem_addr, 16'h2000);
    drain();

    // Random traffic across several latencies.
    for (int seg = 0; seg < 6; seg++) begin
      lat = $urandom_range(1, 8);
      for (int s = 0; s < 400; s++) begin
        if (!drv_i && !i_granted && $urandom_range(0, 7) == 0) begin drv_i = 1; drv_i_addr = 16'($urandom); end
        if (!drv_d && !d_granted && $urandom_range(0, 9) == 0) begin drv_d = 1; drv_d_addr = 16'($urandom); end
        if (drv_i && $urandom_range(0, 3) == 0) drv_i_addr = 16'($urandom);
        if (drv_d && $urandom_range(0, 3) == 0) drv_d_addr = 16'($urandom);
        if (i_granted && drv_i && $urandom_range(0, 29) == 0) drv_i = 0;
        if (d_granted && drv_d && $urandom_range(0, 29) == 0) drv_d = 0;
        if ((cyc + 1 >= m_free || cyc + 1 == m_free - 1) && $urandom_range(0, 9) == 0) drv_stray = 1;
        step();
      end
      drain();
    end

    chk("leftover_expected", exp_iss.size() + exp_wr.size() + exp_dn.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
